// File: rtl/tqvp_pwm_multichannel.sv
// tqvp_pwm_multichannel: multi-channel PWM with prescaler, edge/center counting and double-buffered duty/TOP
module tqvp_pwm_multichannel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  logic [WIDTH-1:0] r_duty [CHANNELS];
  logic [WIDTH-1:0] r_act_duty [CHANNELS];
  logic [WIDTH-1:0] r_top, r_act_top, r_cnt, w_cnt_nxt, w_wdata;
  logic [7:0] r_presc, r_pc;
  logic r_en, r_mode, r_dir, r_pef;
  logic [CHANNELS-1:0] r_pol, r_out;
  logic w_tick, w_top, w_down, w_flat, w_dir_nxt, w_bnd, w_load, w_clr, w_unused;
  assign w_unused = ^ui_in;
  assign w_wdata = data_in[WIDTH-1:0];
  assign w_tick = r_en && (r_pc == r_presc);
  assign w_top = (r_cnt >= r_act_top);
  assign w_down = r_dir || w_top;
  // Edge mode and center mode with TOP=0 both wrap straight to 0 at TOP
  assign w_flat = !r_mode || (r_act_top == '0);
  assign w_cnt_nxt = w_flat ? (w_top ? '0 : r_cnt + 1'b1) : (w_down ? r_cnt - 1'b1 : r_cnt + 1'b1);
  assign w_dir_nxt = w_flat ? 1'b0 : (w_down ? (w_cnt_nxt != '0) : (w_cnt_nxt == r_act_top));
  assign w_bnd = w_flat ? w_top : (w_down && r_cnt == WIDTH'(1));
  assign w_load = !r_en || (w_tick && w_bnd);
  assign w_clr = data_write && address == 4'hC && data_in[0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_duty[n] <= '0;
        r_act_duty[n] <= '0;
      end
      r_top <= '1;
      r_act_top <= '1;
      r_presc <= '0;
      r_pc <= '0;
      r_cnt <= '0;
      r_en <= 1'b0;
      r_mode <= 1'b0;
      r_dir <= 1'b0;
      r_pef <= 1'b0;
      r_pol <= '0;
      r_out <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++)
        if (data_write && address == 4'(n)) r_duty[n] <= w_wdata;
      if (data_write && address == 4'h8) r_top <= w_wdata;
      if (data_write && address == 4'h9) r_presc <= data_in;
      if (data_write && address == 4'hA) {r_mode, r_en} <= data_in[1:0];
      if (data_write && address == 4'hB) r_pol <= data_in[CHANNELS-1:0];
      r_pef <= (w_tick && w_bnd) || (r_pef && !w_clr);
      if (!r_en) begin
        r_pc <= '0;
        r_cnt <= '0;
        r_dir <= 1'b0;
      end else if (w_tick) begin
        r_pc <= '0;
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
      // A live mode switch keeps CNT but restarts the direction as up
      if (data_write && address == 4'hA && data_in[1] != r_mode) r_dir <= 1'b0;
      if (w_load) begin
        r_act_top <= r_top;
        for (int n = 0; n < CHANNELS; n++) r_act_duty[n] <= r_duty[n];
      end
      for (int n = 0; n < CHANNELS; n++)
        r_out[n] <= (r_en && (r_cnt < r_act_duty[n])) ^ r_pol[n];
    end
  end
  always_comb begin
    uo_out = '0;
    for (int i = 0; i < 8; i++) uo_out[i] = r_out[i % CHANNELS];
  end
  always_comb begin
    data_out = '0;
    for (int n = 0; n < CHANNELS; n++)
      if (address == 4'(n)) data_out = 8'(r_duty[n]);
    case (address)
      4'h8: data_out = 8'(r_top);
      4'h9: data_out = r_presc;
      4'hA: data_out = {6'd0, r_mode, r_en};
      4'hB: data_out = 8'(r_pol);
      4'hC: data_out = {7'd0, r_pef};
      4'hD: data_out = 8'(r_cnt);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tqvp_pwm_multichannel.sv
// tb_tqvp_pwm_multichannel: directed and randomized checks of the PWM peripheral against a closed-form model
module tb_tqvp_pwm_multichannel;
  logic clk = 0, rst_n = 0, data_write = 0;
  logic [7:0] ui_in = 0, data_in = 0, uo_out, data_out;
  logic [3:0] address = 0;
  int checks = 0, failures = 0;
  int dty [4];
  logic [3:0] pl;
  tqvp_pwm_multichannel #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc1(input logic w, input logic [3:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    data_write = w;
    @(posedge clk);
    #1;
    data_write = 0;
    address = 4'hD;
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cyc1(1'b1, a, d);
  endtask
  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
    address = 4'hD;
    #1;
  endtask
  // Counter value after k ticks from enable, straight from the period rules
  function automatic int fcnt(int k, int t, bit m);
    int ph;
    if (!m) return k % (t + 1);
    if (t == 0) return 0;
    ph = k % (2 * t);
    return ph <= t ? ph : 2 * t - ph;
  endfunction
  function automatic logic [7:0] fout(int j, int t, bit m, int p);
    logic [7:0] o;
    int cv;
    cv = fcnt((j - 1) / (p + 1), t, m);
    for (int i = 0; i < 8; i++) o[i] = (cv < dty[i % 4]) ^ pl[i % 4];
    return o;
  endfunction
  initial begin
    logic [7:0] v;
    int h0, h1, h2, p, t, k;
    bit m;
    int seq [9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("rst_uo", uo_out, 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      check($sformatf("rst_reg%0d", a), v, a == 8 ? 8'hFF : 8'h00);
    end
    wr(4'h9, 0); wr(4'h8, 9); wr(4'h0, 3); wr(4'h1, 0); wr(4'h2, 10); wr(4'hA, 1);
    h0 = 0; h1 = 0; h2 = 0;
    for (int j = 1; j <= 31; j++) begin
      cyc1(j == 11 || j == 30 || j == 31, 4'hC, 8'h01);
      if (j >= 11 && j <= 20) begin
        h0 += int'(uo_out[0]);
        h1 += int'(uo_out[1]);
        h2 += int'(uo_out[2]);
      end
      if (j == 9 || j == 10 || j == 19 || j == 20 || j == 30 || j == 31) begin
        rd(4'hC, v);
        check($sformatf("pef_j%0d", j), v, (j == 10 || j == 20 || j == 30) ? 1 : 0);
      end
    end
    check("edge_ch0_high", h0, 3);
    check("edge_ch1_high", h1, 0);
    check("edge_ch2_high", h2, 10);
    wr(4'hA, 0); wr(4'h8, 4); wr(4'h9, 1); wr(4'h0, 2); wr(4'hA, 3);
    check("ctr_cnt0", data_out, 0);
    h0 = 0;
    for (int j = 1; j <= 32; j++) begin
      cyc1(0, 0, 0);
      if (j % 2 == 0 && j <= 16) check($sformatf("ctr_cnt_j%0d", j), data_out, seq[j / 2]);
      if (j >= 17) h0 += int'(uo_out[0]);
      if (j == 14 || j == 21) check($sformatf("ctr_edge_lo_j%0d", j), uo_out[0], 0);
      if (j == 15 || j == 20) check($sformatf("ctr_edge_hi_j%0d", j), uo_out[0], 1);
    end
    check("ctr_ch0_high", h0, 6);
    wr(4'hA, 0); wr(4'h9, 0); wr(4'h8, 9); wr(4'h0, 3); wr(4'hA, 1);
    h0 = 0; h1 = 0;
    for (int j = 1; j <= 36; j++) begin
      cyc1(j == 6 || j == 26, j == 6 ? 4'h0 : 4'h8, j == 6 ? 8'd7 : 8'd4);
      if (j >= 7 && j <= 10) h0 += int'(uo_out[0]);
      if (j >= 11 && j <= 20) h1 += int'(uo_out[0]);
      if (j == 29 || j == 30 || j == 34 || j == 35)
        check($sformatf("dbuf_cnt_j%0d", j), data_out, j == 29 ? 9 : (j == 34 ? 4 : 0));
    end
    check("dbuf_old_duty", h0, 0);
    check("dbuf_new_duty", h1, 7);
    wr(4'hA, 0); wr(4'hB, 8'h05);
    cyc1(0, 0, 0);
    check("pol_dis", uo_out, 8'h55);
    wr(4'h0, 0); wr(4'h1, 0); wr(4'h2, 0); wr(4'h3, 0); wr(4'hA, 1);
    for (int j = 1; j <= 4; j++) begin
      cyc1(0, 0, 0);
      check($sformatf("pol_en_j%0d", j), uo_out, 8'h55);
    end
    for (int tr = 0; tr < 10; tr++) begin
      p = int'($urandom_range(0, 3));
      t = int'($urandom_range(0, 12));
      m = 1'($urandom_range(0, 1));
      pl = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) dty[c] = int'($urandom_range(0, t + 2));
      wr(4'hA, 0); wr(4'h9, 8'(p)); wr(4'h8, 8'(t));
      for (int c = 0; c < 4; c++) wr(4'(c), 8'(dty[c]));
      wr(4'hB, {4'd0, pl}); wr(4'hC, 1); wr(4'hA, {6'd0, m, 1'b1});
      for (int j = 1; j <= 40; j++) begin
        cyc1(0, 0, 0);
        check($sformatf("rnd%0d_cnt_j%0d", tr, j), data_out, fcnt(j / (p + 1), t, m));
        check($sformatf("rnd%0d_uo_j%0d", tr, j), uo_out, fout(j, t, m, p));
      end
      rd(4'hC, v);
      k = 40 / (p + 1);
      check($sformatf("rnd%0d_pef", tr), v, m ? (t == 0 ? k >= 1 : k >= 2 * t) : k >= t + 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
